// File: rtl/my_demux_seq.sv
// Registered 1-to-7 demux / serial-to-parallel loader; the receiving end of my_mux.
// Manual writes steer din to the addressed output; auto-scan fills a..g in order.
module my_demux_seq #(
  parameter logic [6:0] RST_VAL      = 7'b0000000,
  parameter bit         CLR_ON_START = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [2:0] addr,
  input  logic       wr_en,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [6:0] q, q_nxt;
  logic       done_nxt, err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      q     <= RST_VAL;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // start wins over a same-cycle wr_en; that write is silently dropped
          state_nxt = SCAN;
          cnt_nxt   = 3'd0;
          if (CLR_ON_START) q_nxt = RST_VAL;
        end else if (wr_en) begin
          if (addr == 3'd7) err_nxt = 1'b1;
          for (int i = 0; i < 7; i++)
            if (addr == 3'(i)) q_nxt[i] = din;
        end
      end
      SCAN: begin
        for (int i = 0; i < 7; i++)
          if (cnt == 3'(i)) q_nxt[i] = din;
        if (cnt == 3'd6) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign {g, f, e, d, c, b, a} = q;
  assign busy = (state == SCAN);

endmodule

// File: tb/tb_my_demux_seq.sv
// Self-checking bench for my_demux_seq: vector table, corner-case sequences,
// and random traffic compared against a bit-array/position reference model.
module tb_my_demux_seq;

  logic       clk = 1'b0, rst = 1'b1, din = 1'b0, wr_en = 1'b0, start = 1'b0;
  logic [2:0] addr = 3'd0;
  logic       a, b, c, d, e, f, g, busy, done, err;

  my_demux_seq #(.RST_VAL(7'b0000000), .CLR_ON_START(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .wr_en(wr_en), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: word as a bit array, scan position -1 when idle
  bit [6:0] m_q;
  int       m_pos;
  bit       m_done, m_err;

  function automatic void model_reset();
    m_q = 7'b0; m_pos = -1; m_done = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(bit dd, bit [2:0] ad, bit w, bit s);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_pos < 0) begin
      if (s) begin
        m_pos = 0;
        m_q   = 7'b0;
      end else if (w) begin
        if (ad < 3'd7) m_q[ad] = dd;
        else           m_err = 1'b1;
      end
    end else begin
      m_q[m_pos] = dd;
      m_pos++;
      if (m_pos == 7) begin
        m_pos  = -1;
        m_done = 1'b1;
      end
    end
  endfunction

  function automatic logic [9:0] mvec();
    return {m_q, (m_pos >= 0), m_done, m_err};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {g, f, e, d, c, b, a, busy, done, err};
  endfunction

  task automatic check(input string nm, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got q=%b busy=%b done=%b err=%b, want q=%b busy=%b done=%b err=%b",
               nm, got[9:3], got[2], got[1], got[0], exp[9:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input bit dd, input bit [2:0] ad, input bit w, input bit s);
    din = dd; addr = ad; wr_en = w; start = s;
    model_step(dd, ad, w, s);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string    name;
    bit       din;
    bit [2:0] addr;
    bit       wr;
    bit       st;
    bit [6:0] q;
    bit       busy, done, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, bit dd, bit [2:0] ad, bit w, bit s,
                              bit [6:0] q, bit bz, bit dn, bit er);
    vec_t v;
    v.name = n; v.din = dd; v.addr = ad; v.wr = w; v.st = s;
    v.q = q; v.busy = bz; v.done = dn; v.err = er;
    return v;
  endfunction

  bit [6:0] pat;

  initial begin
    tbl.push_back(mk("wr_a",     1, 0, 1, 0, 7'b0000001, 0, 0, 0));
    tbl.push_back(mk("wr_b",     1, 1, 1, 0, 7'b0000011, 0, 0, 0));
    tbl.push_back(mk("wr_e",     1, 4, 1, 0, 7'b0010011, 0, 0, 0));
    tbl.push_back(mk("wr_c0",    0, 2, 1, 0, 7'b0010011, 0, 0, 0));
    tbl.push_back(mk("wr_g",     1, 6, 1, 0, 7'b1010011, 0, 0, 0));
    tbl.push_back(mk("wr_bad",   1, 7, 1, 0, 7'b1010011, 0, 0, 1));
    tbl.push_back(mk("err_drop", 1, 7, 0, 0, 7'b1010011, 0, 0, 0));
    tbl.push_back(mk("start",    0, 0, 0, 1, 7'b0000000, 1, 0, 0));
    tbl.push_back(mk("cap_a",    1, 0, 0, 0, 7'b0000001, 1, 0, 0));
    tbl.push_back(mk("cap_b",    1, 0, 0, 0, 7'b0000011, 1, 0, 0));
    tbl.push_back(mk("cap_c",    0, 0, 0, 0, 7'b0000011, 1, 0, 0));
    tbl.push_back(mk("cap_d",    0, 0, 0, 0, 7'b0000011, 1, 0, 0));
    tbl.push_back(mk("cap_e",    1, 0, 0, 0, 7'b0010011, 1, 0, 0));
    tbl.push_back(mk("cap_f",    0, 0, 0, 0, 7'b0010011, 1, 0, 0));
    tbl.push_back(mk("cap_g",    0, 0, 0, 0, 7'b0010011, 0, 1, 0));
    tbl.push_back(mk("post_scan",0, 0, 0, 0, 7'b0010011, 0, 0, 0));

    model_reset();
    #2;
    check("reset", dut_vec(), 10'b0);
    #10 rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].din, tbl[i].addr, tbl[i].wr, tbl[i].st);
      check(tbl[i].name, dut_vec(), {tbl[i].q, tbl[i].busy, tbl[i].done, tbl[i].err});
      check({tbl[i].name, "_model"}, dut_vec(), mvec());
    end

    // preset all ones, then a scan that sees wr_en/start interference
    for (int i = 0; i < 7; i++) drive(1, 3'(i), 1, 0);
    check("preset", dut_vec(), {7'b1111111, 3'b000});
    drive(0, 0, 0, 1);
    check("clr_on_start", dut_vec(), {7'b0000000, 3'b100});
    pat = 7'b1011010;
    for (int i = 0; i < 7; i++) begin
      drive(pat[i], 3'd3, (i >= 1 && i <= 3), (i >= 2 && i <= 4));
      check("interfere", dut_vec(), mvec());
    end
    check("interfere_final", dut_vec(), {7'b1011010, 3'b010});

    // reset mid-scan: must act without a clock edge
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
    check("pre_rst", dut_vec(), {7'b0000111, 3'b100});
    rst = 1'b1;
    model_reset();
    #2;
    check("async_rst", dut_vec(), 10'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0);
    check("rst_no_done", dut_vec(), 10'b0);
    drive(1, 5, 1, 0);
    check("rst_wr_f", dut_vec(), {7'b0100000, 3'b000});

    // start held through done restarts on the following edge
    for (int i = 0; i < 9; i++) begin
      drive(1'(i & 1), 0, 0, 1);
      check("start_held", dut_vec(), mvec());
    end
    check("restart_busy", {7'b0, busy, 2'b0}, {7'b0, 1'b1, 2'b0});
    start = 1'b0;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);
    check("restart_end", dut_vec(), mvec());

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0));
      check("rand", dut_vec(), mvec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/my_demux_seq.md
Name: my_demux_seq

Overview:
- Registered 1-to-7 demultiplexer and serial-to-parallel loader, the receiving end of my_mux.
- my_mux picks one of seven lines (a..g) by a 3-bit address. This block takes one serial bit plus an address and steers it into the matching output register a..g.
- An auto-scan mode captures seven consecutive bits into a..g in order. This rebuilds a parallel word from a stream produced by sweeping my_mux through addresses 0..6.

Parameters:
- RST_VAL, 7'b0000000, reset and clear value of {g,f,e,d,c,b,a}. Bit 0 maps to a.
- CLR_ON_START, 1, when 1 a scan start loads all outputs with RST_VAL before capture begins.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- din  input  1  serial data bit
- addr  input  3  destination select: 0→a, 1→b, 2→c, 3→d, 4→e, 5→f, 6→g. 7 is invalid.
- wr_en  input  1  manual write strobe
- start  input  1  auto-scan start strobe
- a, b, c, d, e, f, g  output  1 each  registered demux outputs
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse when a scan completes
- err  output  1  one-cycle pulse on a manual write to addr 7

Behaviour:
- Reset (async, rst=1):
  - {g..a}=RST_VAL; busy=0, done=0, err=0.
  - Scan counter=0; state=IDLE.
  - Takes effect immediately and overrides everything, including mid-scan. After release the block is in IDLE and ignores the scan it was running.
- States: IDLE and SCAN. The internal 3-bit counter cnt is meaningful only in SCAN.
- IDLE, wr_en=1 and addr<=6:
  - On the next rising edge the output selected by addr takes din. The other six outputs hold.
  - Latency: 1 clock from the sampling edge to the output change.
- IDLE, wr_en=1 and addr=7: no output changes; err=1 for exactly one cycle.
- IDLE, start=1:
  - Next state SCAN, cnt=0, busy=1 from that edge.
  - If CLR_ON_START=1, all outputs load RST_VAL on the same edge.
  - start has priority over wr_en in the same cycle; that wr_en is dropped and err is not raised.
- SCAN, each edge: output[cnt] takes din, then cnt increments.
  - First capture is on the edge after the start edge, so din for a is presented in the cycle after start is sampled.
  - The edge that captures g (cnt=6) returns the state to IDLE, drops busy, and sets done=1 for one cycle.
  - A scan takes exactly 7 capture edges. Start edge to done high is 8 edges.
- SCAN, wr_en, addr, and start are ignored. No err, no restart.
- A start held high through the done edge begins a new scan on the following edge, because the block is back in IDLE by then.
- Outputs never glitch between edges; all are flop outputs.
- din is sampled only when used; its value is don't-care otherwise.

Test Plan:
- Reset: rst=1 mid-run with RST_VAL=0 → immediately a..g=0, busy=0, done=0, err=0, without waiting for a clock.
- Manual writes:
  - Sequence with din=1: (wr_en, addr=0), then addr=1, then addr=4.
  - Then din=0 at addr=2, then din=1 at addr=6.
  - Required: {g..a}=7'b1010011 after the last edge; each change exactly 1 edge after its write.
- Invalid address: wr_en=1, addr=7, din=1 → outputs unchanged, err high for exactly 1 cycle.
- Auto-scan:
  - Pulse start, then drive din=1,1,0,0,1,0,0 on successive cycles.
  - Required: {g..a}=7'b0010011 (a=1, b=1, e=1, rest 0).
  - busy high for 7 cycles; done pulses once at edge 8 after start.
- Scan with interference:
  - With CLR_ON_START=1 and outputs preset to 7'b1111111, pulse start → outputs read 0 on the start edge.
  - During the scan assert wr_en addr=3 and start again → both ignored, err stays 0, final result set by din only.
- Reset mid-scan: assert rst after the 3rd capture → outputs=RST_VAL, busy=0, no done pulse.
  - After release, a manual write addr=5 din=1 → only f=1.
